imm_decode_pipe: RTL and testbench

IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

---
 rtl/imm_decode_pipe.sv | 175 +++++++++++++++++
 tb/tb_imm_decode_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_pipe.sv
// RV32I immediate decoder with a two-entry (output + skid) elastic buffer.
// Optional macro IMMDEC_ILLEGAL_CHK_EN flags unlisted opcodes as illegal (fmt=7).
module imm_decode_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] extimm,
  output logic [2:0]      fmt,
  output logic [31:0]     instr_q,
  output logic            illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [XLEN-1:0] dec_imm_s;
  logic [2:0]      dec_fmt_s;
  logic            dec_ill_s;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [2:0]      out_fmt_q, out_fmt_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic            out_ill_q, out_ill_d;

  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic [2:0]      skid_fmt_q, skid_fmt_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic            skid_ill_q, skid_ill_d;

  logic            in_ready_q, in_ready_d;
  logic            accept_s, drain_s;

  // Format decode and sign extension of the incoming word
  always_comb begin
    dec_imm_s = '0;
    dec_fmt_s = FMT_R;
    dec_ill_s = 1'b0;
    case (instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        dec_fmt_s = FMT_I;
        dec_imm_s = XLEN'($signed(instr[31:20]));
      end
      7'b0100011: begin
        dec_fmt_s = FMT_S;
        dec_imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      7'b1100011: begin
        dec_fmt_s = FMT_B;
        dec_imm_s = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt_s = FMT_U;
        dec_imm_s = XLEN'($signed({instr[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec_fmt_s = FMT_J;
        dec_imm_s = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      7'b0110011, 7'b1110011, 7'b0001111: begin
        dec_fmt_s = FMT_R;
      end
      default: begin
`ifdef IMMDEC_ILLEGAL_CHK_EN
        dec_fmt_s = FMT_ILL;
        dec_ill_s = 1'b1;
`else
        dec_fmt_s = FMT_R;
        dec_ill_s = 1'b0;
`endif
      end
    endcase
  end

  assign accept_s = in_valid && in_ready_q;
  assign drain_s  = out_valid_q && out_ready;

  // Output/skid steering; in_ready is derived from the next skid state so it stays registered
  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    out_instr_d  = out_instr_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_instr_d = skid_instr_q;
    skid_ill_d   = skid_ill_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (drain_s) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_fmt_d    = skid_fmt_q;
        out_instr_d  = skid_instr_q;
        out_ill_d    = skid_ill_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b1;
      end
    end else if (!out_valid_q || drain_s) begin
      out_valid_d = accept_s;
      if (accept_s) begin
        out_imm_d   = dec_imm_s;
        out_fmt_d   = dec_fmt_s;
        out_instr_d = instr;
        out_ill_d   = dec_ill_s;
      end else begin
        out_imm_d   = out_imm_q;
      end
    end else if (accept_s) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm_s;
      skid_fmt_d   = dec_fmt_s;
      skid_instr_d = instr;
      skid_ill_d   = dec_ill_s;
    end else begin
      skid_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= 3'd0;
      out_instr_q  <= 32'd0;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= 3'd0;
      skid_instr_q <= 32'd0;
      skid_ill_q   <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      out_instr_q  <= out_instr_d;
      out_ill_q    <= out_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_instr_q <= skid_instr_d;
      skid_ill_q   <= skid_ill_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign extimm    = out_imm_q;
  assign fmt       = out_fmt_q;
  assign instr_q   = out_instr_q;
  assign illegal   = out_ill_q;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Scoreboard bench for imm_decode_pipe: arithmetic reference model, queue of expected
// entries pushed on accept, independent monitor popping on each output transfer.
module tb_imm_decode_pipe;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic        in_ready, out_valid, illegal;
  logic [31:0] extimm, instr_q;
  logic [2:0]  fmt;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] extimm64;
  logic [31:0] instr_q64;
  logic [2:0]  fmt64;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] ins;
  } exp_t;

  exp_t sb[$];

  imm_decode_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .extimm(extimm),
    .fmt(fmt), .instr_q(instr_q), .illegal(illegal));

  imm_decode_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .out_valid(out_valid64), .out_ready(out_ready), .extimm(extimm64),
    .fmt(fmt64), .instr_q(instr_q64), .illegal(illegal64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: gather immediate bits arithmetically, then two's-complement sign them.
  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    longint unsigned u;
    longint v;
    int w;
    u = 64'(ins);
    v = 0; w = 0;
    e.ins = ins; e.fmt = 3'd0; e.ill = 1'b0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: begin e.fmt = 3'd1; w = 12; v = longint'((u >> 20) & 4095); end
      7'h23: begin e.fmt = 3'd2; w = 12; v = longint'(((u >> 25) << 5) | ((u >> 7) & 31)); end
      7'h63: begin
        e.fmt = 3'd3; w = 13;
        v = longint'(((u >> 31) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1));
      end
      7'h37, 7'h17: begin e.fmt = 3'd4; w = 32; v = longint'((u >> 12) << 12); end
      7'h6F: begin
        e.fmt = 3'd5; w = 21;
        v = longint'(((u >> 31) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1));
      end
      7'h33, 7'h73, 7'h0F: e.fmt = 3'd0;
      default: begin
`ifdef IMMDEC_ILLEGAL_CHK_EN
        e.fmt = 3'd7; e.ill = 1'b1;
`endif
      end
    endcase
    if (w > 0 && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    e.imm = v[31:0];
    return e;
  endfunction

  // Expected-entry producer: record every accepted, non-flushed input
  always @(negedge clk) begin
    if (!rst_n || flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(model(instr));
  end

  logic        hold_v = 1'b0;
  logic [31:0] hold_imm, hold_ins;
  logic [2:0]  hold_fmt;
  logic        hold_ill;
  exp_t        cur;

  // Monitor: stability while stalled, and in-order comparison on each output transfer
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid)
        chk("stall_stable", {extimm, instr_q}, {hold_imm, hold_ins});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 64'(out_valid), 64'd0);
        else begin
          cur = sb.pop_front();
          chk("sb_extimm", 64'(extimm), 64'(cur.imm));
          chk("sb_fmt_ill_ins", {28'd0, fmt, illegal, instr_q}, {28'd0, cur.fmt, cur.ill, cur.ins});
        end
      end
      hold_v = out_valid && !out_ready;
      hold_imm = extimm; hold_ins = instr_q; hold_fmt = fmt; hold_ill = illegal;
    end
  end

  task automatic send(input logic [31:0] w);
    bit got;
    instr = w;
    in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) chk("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [31:0] stream [4] = '{32'hFFF00093, 32'hFE112E23, 32'h123452B7, 32'hFF9FF06F};
  logic [31:0] s_imm  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFF8};
  logic [2:0]  s_fmt  [4] = '{3'd1, 3'd2, 3'd4, 3'd5};
  logic [6:0]  opc    [11] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73, 7'h0F};

  initial begin
    logic [31:0] r;
    bit done;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 32'd0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", {fmt, illegal, extimm, instr_q}, 68'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Streaming with 1-cycle latency, plus XLEN=64 sign extension
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(stream[i]);
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_imm", 64'(extimm), 64'(s_imm[i]));
      chk("stream_fmt", 64'(fmt), 64'(s_fmt[i]));
      if (i == 0) begin
        chk("x64_imm", extimm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("x64_fmt_ill", {fmt64, illegal64, out_valid64, in_ready64}, {3'd1, 1'b0, 1'b1, 1'b1});
        chk("x64_instr", 64'(instr_q64), 64'(stream[0]));
      end
    end
    idle(2);

    // Unlisted opcode
    send(32'h0000007F);
`ifdef IMMDEC_ILLEGAL_CHK_EN
    chk("illegal_opc", {fmt, illegal}, {3'd7, 1'b1});
`else
    chk("illegal_opc", {fmt, illegal}, {3'd0, 1'b0});
`endif
    chk("illegal_imm", 64'(extimm), 64'd0);
    idle(2);

    // Backpressure: fill output + skid, third input stalls, then drain in order
    out_ready = 1'b0;
    send(32'h00A00513);
    chk("bp_ready1", 64'(in_ready), 64'd1);
    send(32'hFE0008E3);
    chk("bp_ready2", 64'(in_ready), 64'd0);
    instr = 32'h800000EF; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_stall", {in_ready, out_valid, instr_q}, {1'b0, 1'b1, 32'h00A00513});
    end
    out_ready = 1'b1;
    send(32'h800000EF);
    idle(4);
    chk("bp_empty", 64'(sb.size()), 64'd0);

    // Flush with both entries full and a pending input
    out_ready = 1'b0;
    send(32'h12345037);
    send(32'h00112023);
    instr = 32'h00000013; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    idle(2);
    chk("flush_dropped", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-transfer
    send(32'hFFF00093);
    send(32'h0000006F);
    in_valid = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_outputs", {in_ready, fmt, illegal, extimm, instr_q}, 69'd0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_release", {in_ready, out_valid}, 2'b10);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      r = $urandom;
      r[6:0] = ($urandom_range(0, 11) == 11) ? 7'($urandom) : opc[$urandom_range(0, 10)];
      instr = r;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 40) == 0);
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !out_valid) done = 1'b1;
    end
    chk("final_drain", {32'(sb.size()), 31'd0, out_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
